epoch_to_bcd_datetime: RTL

Sequential converter between the network time fetch stage and the clock/display interface.
- Accepts a 32-bit Unix epoch seconds value, for example the network time result, on a start pulse.
- Applies a fixed time-zone offset.
- Produces BCD year/month/day/hour/minute/second plus a one-cycle load strobe that presets the running clock.
- Uses an iterative restoring divider and a year/month walk instead of wide combinational arithmetic.

---
 rtl/epoch_to_bcd_datetime_pkg.sv | 68 ++++++
 rtl/epoch_to_bcd_datetime_seq_div32.sv | 57 +++++
 rtl/epoch_to_bcd_datetime.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/epoch_to_bcd_datetime_pkg.sv
// Shared types, constants and helpers for the epoch -> BCD date/time converter.
// Optional weekday output is controlled by the EPOCH_WEEKDAY_EN macro.
package epoch_to_bcd_datetime_pkg;

    typedef enum logic [3:0] {
        IDLE, ADJ, DIV_DAY, DIV_HOUR, DIV_MIN, DIV_WD, YEAR, MONTH, OUT
    } state_t;

    localparam logic [31:0] SEC_PER_DAY  = 32'd86400;
    localparam logic [31:0] SEC_PER_HOUR = 32'd3600;
    localparam logic [31:0] SEC_PER_MIN  = 32'd60;
    localparam logic [11:0] EPOCH_YEAR   = 12'd1970;

    localparam logic [15:0] RST_YEAR_BCD  = 16'h1970;
    localparam logic [7:0]  RST_MONTH_BCD = 8'h01;
    localparam logic [7:0]  RST_DAY_BCD   = 8'h01;
    localparam logic [7:0]  RST_HMS_BCD   = 8'h00;
    localparam logic [2:0]  RST_WEEKDAY   = 3'd4;

    // Gregorian leap rule restricted to 1970..2106: only 2100 is a century year.
    function automatic logic is_leap(input logic [11:0] y);
        return (y[1:0] == 2'd0) && (y != 12'd2100);
    endfunction

    // Month-length ROM; m is binary 1..12.
    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                        month_len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:     month_len = 5'd30;
            default:                     month_len = 5'd31;
        endcase
    endfunction

    // Four-digit BCD increment, each digit wraps at 9 and carries upward.
    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Binary 0..59 to two BCD digits by counting tens (at most five).
    function automatic logic [7:0] to_bcd8(input logic [5:0] v);
        logic [2:0] tens;
        logic [5:0] r;
        tens = 3'd0;
        r    = v;
        for (int i = 0; i < 5; i++) begin
            if (r >= 6'd10) begin
                r    = r - 6'd10;
                tens = tens + 3'd1;
            end
        end
        return {1'b0, tens, r[3:0]};
    endfunction

endpackage

// File: rtl/epoch_to_bcd_datetime_seq_div32.sv
// seq_div32: restoring 32/32 divider. One load cycle (start), then 32 shift/
// subtract steps; done is high for the single cycle after the last step.
module seq_div32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);
    logic [31:0] q, r, dvs;
    logic [5:0]  cnt;
    logic        run;
    logic [32:0] r_sh, r_sub;

    // Trial subtraction: borrow out of bit 32 means the shifted remainder is smaller.
    always_comb begin
        r_sh  = {r, q[31]};
        r_sub = r_sh - {1'b0, dvs};
    end

    assign done      = run && (cnt == 6'd32);
    assign quotient  = q;
    assign remainder = r;

    // Iteration state; a new start always wins, even in the done cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q   <= '0;
            r   <= '0;
            dvs <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            q   <= dividend;
            r   <= '0;
            dvs <= divisor;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (cnt != 6'd32) begin
                cnt <= cnt + 6'd1;
                if (!r_sub[32]) begin
                    r <= r_sub[31:0];
                    q <= {q[30:0], 1'b1};
                end else begin
                    r <= r_sh[31:0];
                    q <= {q[30:0], 1'b0};
                end
            end else begin
                run <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/epoch_to_bcd_datetime.sv
// epoch_to_bcd_datetime: converts Unix seconds (plus a fixed zone offset) to
// BCD calendar date/time using one shared sequential divider and a year/month
// walk. Define EPOCH_WEEKDAY_EN to add the weekday output and its divide pass.
module epoch_to_bcd_datetime
    import epoch_to_bcd_datetime_pkg::*;
#(
    parameter int signed   TZ_OFFSET_S  = 28800,
    parameter logic [15:0] YEAR_MAX_BCD = 16'h2106
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] epoch,
    output logic        busy,
    output logic        done,
    output logic [15:0] year_bcd,
    output logic [7:0]  month_bcd,
    output logic [7:0]  day_bcd,
    output logic [7:0]  hour_bcd,
    output logic [7:0]  minute_bcd,
    output logic [7:0]  second_bcd
`ifdef EPOCH_WEEKDAY_EN
    ,
    output logic [2:0]  weekday
`endif
);
    localparam logic signed [33:0] TZ34 = {{2{TZ_OFFSET_S[31]}}, TZ_OFFSET_S};

    state_t      state;
    logic [31:0] epoch_q;
    logic [16:0] days, d;
    logic [4:0]  hour_q;
    logic [5:0]  min_q, sec_q;
    logic [11:0] yr;
    logic [15:0] yr_bcd;
    logic [3:0]  m;
    logic [7:0]  m_bcd;
`ifdef EPOCH_WEEKDAY_EN
    logic [2:0]  wd_q;
`endif

    logic signed [33:0] t_sum;
    logic [31:0] t_adj;
    logic [8:0]  ylen;
    logic [4:0]  mlen;
    logic        div_start, div_done;
    logic [31:0] div_dividend, div_divisor, div_quot, div_rem;
    logic        unused_quot_hi;

    assign unused_quot_hi = ^div_quot[31:17];

    // Zone offset with saturation into the unsigned 32-bit range.
    always_comb begin
        t_sum = $signed({2'b00, epoch_q}) + TZ34;
        if (t_sum[33])      t_adj = 32'd0;
        else if (t_sum[32]) t_adj = 32'hFFFF_FFFF;
        else                t_adj = t_sum[31:0];
    end

    // Current year and month lengths for the walk.
    always_comb begin
        ylen = is_leap(yr) ? 9'd366 : 9'd365;
        mlen = month_len(m, is_leap(yr));
    end

    // Divider sequencing: the next pass loads in the cycle the previous one finishes.
    always_comb begin
        div_start    = 1'b0;
        div_dividend = t_adj;
        div_divisor  = SEC_PER_DAY;
        case (state)
            ADJ: div_start = 1'b1;
            DIV_DAY: if (div_done) begin
                div_start    = 1'b1;
                div_dividend = div_rem;
                div_divisor  = SEC_PER_HOUR;
            end
            DIV_HOUR: if (div_done) begin
                div_start    = 1'b1;
                div_dividend = div_rem;
                div_divisor  = SEC_PER_MIN;
            end
`ifdef EPOCH_WEEKDAY_EN
            DIV_MIN: if (div_done) begin
                div_start    = 1'b1;
                div_dividend = {15'd0, days} + 32'd4;
                div_divisor  = 32'd7;
            end
`endif
            default: ;
        endcase
    end

    seq_div32 u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_quot),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Main conversion FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            year_bcd   <= RST_YEAR_BCD;
            month_bcd  <= RST_MONTH_BCD;
            day_bcd    <= RST_DAY_BCD;
            hour_bcd   <= RST_HMS_BCD;
            minute_bcd <= RST_HMS_BCD;
            second_bcd <= RST_HMS_BCD;
            epoch_q    <= '0;
            days       <= '0;
            d          <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            yr         <= EPOCH_YEAR;
            yr_bcd     <= RST_YEAR_BCD;
            m          <= 4'd1;
            m_bcd      <= 8'h01;
`ifdef EPOCH_WEEKDAY_EN
            wd_q       <= RST_WEEKDAY;
            weekday    <= RST_WEEKDAY;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !done) begin
                    epoch_q <= epoch;
                    busy    <= 1'b1;
                    state   <= ADJ;
                end
                ADJ: state <= DIV_DAY;
                DIV_DAY: if (div_done) begin
                    days  <= div_quot[16:0];
                    state <= DIV_HOUR;
                end
                DIV_HOUR: if (div_done) begin
                    hour_q <= div_quot[4:0];
                    state  <= DIV_MIN;
                end
                DIV_MIN: if (div_done) begin
                    min_q  <= div_quot[5:0];
                    sec_q  <= div_rem[5:0];
                    d      <= days;
                    yr     <= EPOCH_YEAR;
                    yr_bcd <= RST_YEAR_BCD;
                    m      <= 4'd1;
                    m_bcd  <= 8'h01;
`ifdef EPOCH_WEEKDAY_EN
                    state  <= DIV_WD;
`else
                    state  <= YEAR;
`endif
                end
`ifdef EPOCH_WEEKDAY_EN
                DIV_WD: if (div_done) begin
                    wd_q  <= div_rem[2:0];
                    state <= YEAR;
                end
`endif
                YEAR: begin
                    if ((yr_bcd != YEAR_MAX_BCD) && (d >= {8'd0, ylen})) begin
                        d      <= d - {8'd0, ylen};
                        yr     <= yr + 12'd1;
                        yr_bcd <= bcd_inc16(yr_bcd);
                    end else begin
                        state <= MONTH;
                    end
                end
                MONTH: begin
                    if (d >= {12'd0, mlen}) begin
                        d     <= d - {12'd0, mlen};
                        m     <= m + 4'd1;
                        m_bcd <= (m_bcd[3:0] == 4'd9) ? 8'h10 : m_bcd + 8'd1;
                    end else begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    year_bcd   <= yr_bcd;
                    month_bcd  <= m_bcd;
                    day_bcd    <= to_bcd8({1'b0, d[4:0]} + 6'd1);
                    hour_bcd   <= to_bcd8({1'b0, hour_q});
                    minute_bcd <= to_bcd8(min_q);
                    second_bcd <= to_bcd8(sec_q);
`ifdef EPOCH_WEEKDAY_EN
                    weekday    <= wd_q;
`endif
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
